// File: rtl/udp_receiver.sv
// rtl/udp_receiver.sv - Ethernet II / IPv4 / UDP receive parser with MAC, IP and port filtering; optional FCS check under UDP_RX_CRC_EN
module udp_receiver #(
  parameter logic [47:0] LOCAL_MAC = 48'h11_11_11_11_11_11,
  parameter logic [31:0] LOCAL_IP  = 32'hC0_A8_01_6E,
  parameter logic [15:0] LOCL_PORT = 16'h8080
) (
  input  logic        rgmii_clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_error,
  output logic        udp_rec_data_valid,
  output logic [7:0]  udp_rec_rdata,
  output logic        udp_rec_sop,
  output logic        udp_rec_eop,
  output logic [15:0] udp_rec_data_length,
  output logic [31:0] udp_rec_src_ip,
  output logic [15:0] udp_rec_src_port,
  output logic        udp_rec_err,
  output logic        frame_drop
);

  typedef enum logic [3:0] {
    WAIT_IDLE, IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TAIL, DISCARD
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        mac_loc_q, mac_loc_d;
  logic        mac_bc_q, mac_bc_d;
  logic [31:0] sip_q, sip_d;
  logic [15:0] sport_q, sport_d;
  logic [15:0] ulen_q, ulen_d;
  logic [15:0] rem_q, rem_d;
  logic        first_q, first_d;
  logic        dv_q, dv_d;
  logic [7:0]  data_q, data_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic [15:0] len_q, len_d;
  logic [31:0] oip_q, oip_d;
  logic [15:0] oport_q, oport_d;
  logic        err_q, err_d;
  logic        drop_q, drop_d;
  logic        hdr_fail;

  // Byte-lane selectors: header fields arrive MSB first, so byte k of a field sits at the top minus k.
  logic [5:0] mac_idx;
  logic [4:0] ip_idx;
  logic [3:0] port_idx;
  assign mac_idx  = {3'd5 - cnt_q[2:0], 3'b000};
  assign ip_idx   = {2'd3 - cnt_q[1:0], 3'b000};
  assign port_idx = {~cnt_q[0], 3'b000};

`ifdef UDP_RX_CRC_EN
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
  logic [31:0] crc_q, crc_d;
  logic [31:0] crc_rev;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // The register runs LSB-first; reverse it to compare against the conventional residue.
  assign crc_rev = {<<{crc_q}};

  // Running CRC from the first destination MAC byte through the FCS; re-seeded while hunting for SFD.
  always_comb begin
    crc_d = crc_q;
    if (state_q inside {IDLE, PREAMBLE}) begin
      crc_d = 32'hFFFFFFFF;
    end else if (rx_valid && (state_q inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TAIL})) begin
      crc_d = crc_byte(crc_q, rx_data);
    end
  end

  // CRC accumulator register.
  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) crc_q <= 32'hFFFFFFFF;
    else       crc_q <= crc_d;
  end
`endif

  // Parser next state, header filtering and registered output values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mac_loc_d = mac_loc_q;
    mac_bc_d  = mac_bc_q;
    sip_d     = sip_q;
    sport_d   = sport_q;
    ulen_d    = ulen_q;
    rem_d     = rem_q;
    first_d   = first_q;
    dv_d      = 1'b0;
    data_d    = data_q;
    sop_d     = 1'b0;
    eop_d     = 1'b0;
    len_d     = len_q;
    oip_d     = oip_q;
    oport_d   = oport_q;
    err_d     = 1'b0;
    drop_d    = 1'b0;
    hdr_fail  = 1'b0;
    if (rx_valid && rx_error && !(state_q inside {WAIT_IDLE, DISCARD})) begin
      err_d   = 1'b1;
      state_d = DISCARD;
    end else if (!rx_valid && (state_q inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD})) begin
      // Frame ended before the payload count ran out.
      err_d   = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        WAIT_IDLE: if (!rx_valid) state_d = IDLE;
        IDLE, PREAMBLE: begin
          cnt_d     = '0;
          mac_loc_d = 1'b1;
          mac_bc_d  = 1'b1;
          if (!rx_valid)               state_d = IDLE;
          else if (rx_data == 8'h55)   state_d = PREAMBLE;
          else if (rx_data == 8'hD5)   state_d = ETH_HDR;
          else                         state_d = DISCARD;
        end
        ETH_HDR: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q < 5'd6) begin
            mac_loc_d = mac_loc_q && (rx_data == LOCAL_MAC[mac_idx +: 8]);
            mac_bc_d  = mac_bc_q && (rx_data == 8'hFF);
            hdr_fail  = !mac_loc_d && !mac_bc_d;
          end
          if (cnt_q == 5'd12 && rx_data != 8'h08) hdr_fail = 1'b1;
          if (cnt_q == 5'd13) begin
            if (rx_data != 8'h00) hdr_fail = 1'b1;
            cnt_d   = '0;
            state_d = IP_HDR;
          end
        end
        IP_HDR: begin
          cnt_d = cnt_q + 5'd1;
          case (cnt_q)
            5'd0:  hdr_fail = (rx_data != 8'h45);
            5'd6:  hdr_fail = (rx_data[5:0] != 6'd0);  // MF and fragment offset high bits
            5'd7:  hdr_fail = (rx_data != 8'h00);
            5'd9:  hdr_fail = (rx_data != 8'd17);
            5'd12, 5'd13, 5'd14, 5'd15: sip_d = {sip_q[23:0], rx_data};
            5'd16, 5'd17, 5'd18: hdr_fail = (rx_data != LOCAL_IP[ip_idx +: 8]);
            5'd19: begin
              hdr_fail = (rx_data != LOCAL_IP[ip_idx +: 8]);
              cnt_d    = '0;
              state_d  = UDP_HDR;
            end
            default: ;
          endcase
        end
        UDP_HDR: begin
          cnt_d = cnt_q + 5'd1;
          case (cnt_q)
            5'd0, 5'd1: sport_d  = {sport_q[7:0], rx_data};
            5'd2, 5'd3: hdr_fail = (rx_data != LOCL_PORT[port_idx +: 8]);
            5'd4:       ulen_d   = {ulen_q[7:0], rx_data};
            5'd5: begin
              ulen_d   = {ulen_q[7:0], rx_data};
              hdr_fail = ({ulen_q[7:0], rx_data} < 16'd8);
            end
            5'd7: begin
              rem_d   = ulen_q - 16'd8;
              first_d = 1'b1;
              cnt_d   = '0;
              state_d = (ulen_q == 16'd8) ? TAIL : PAYLOAD;
            end
            default: ;
          endcase
        end
        PAYLOAD: begin
          dv_d    = 1'b1;
          data_d  = rx_data;
          sop_d   = first_q;
          eop_d   = (rem_q == 16'd1);
          first_d = 1'b0;
          rem_d   = rem_q - 16'd1;
          if (first_q) begin
            len_d   = rem_q;
            oip_d   = sip_q;
            oport_d = sport_q;
          end
          if (rem_q == 16'd1) state_d = TAIL;
        end
        TAIL: begin
          if (!rx_valid) begin
            state_d = IDLE;
`ifdef UDP_RX_CRC_EN
            err_d = (crc_rev != CRC_RESIDUE);
`else
            err_d = 1'b0;
`endif
          end
        end
        DISCARD: if (!rx_valid) state_d = IDLE;
        default: state_d = WAIT_IDLE;
      endcase
      if (hdr_fail) begin
        state_d = DISCARD;
        drop_d  = 1'b1;
      end
    end
  end

  // Parser state, latched header fields and output register stage.
  always_ff @(posedge rgmii_clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= WAIT_IDLE;
      cnt_q     <= '0;
      mac_loc_q <= 1'b0;
      mac_bc_q  <= 1'b0;
      sip_q     <= '0;
      sport_q   <= '0;
      ulen_q    <= '0;
      rem_q     <= '0;
      first_q   <= 1'b0;
      dv_q      <= 1'b0;
      data_q    <= '0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      len_q     <= '0;
      oip_q     <= '0;
      oport_q   <= '0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mac_loc_q <= mac_loc_d;
      mac_bc_q  <= mac_bc_d;
      sip_q     <= sip_d;
      sport_q   <= sport_d;
      ulen_q    <= ulen_d;
      rem_q     <= rem_d;
      first_q   <= first_d;
      dv_q      <= dv_d;
      data_q    <= data_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      len_q     <= len_d;
      oip_q     <= oip_d;
      oport_q   <= oport_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
    end
  end

  assign udp_rec_data_valid  = dv_q;
  assign udp_rec_rdata       = data_q;
  assign udp_rec_sop         = sop_q;
  assign udp_rec_eop         = eop_q;
  assign udp_rec_data_length = len_q;
  assign udp_rec_src_ip      = oip_q;
  assign udp_rec_src_port    = oport_q;
  assign udp_rec_err         = err_q;
  assign frame_drop          = drop_q;

endmodule

// File: tb/tb_udp_receiver.sv
// tb/tb_udp_receiver.sv - randomized self-checking bench for udp_receiver against a frame-level reference model
module tb_udp_receiver;

  localparam logic [47:0] LMAC  = 48'h11_11_11_11_11_11;
  localparam logic [31:0] LIP   = 32'hC0_A8_01_6E;
  localparam logic [15:0] LPORT = 16'h8080;
`ifdef UDP_RX_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        rgmii_clk = 1'b0;
  logic        rstn      = 1'b1;
  logic        rx_valid  = 1'b0;
  logic [7:0]  rx_data   = 8'h00;
  logic        rx_error  = 1'b0;
  logic        udp_rec_data_valid;
  logic [7:0]  udp_rec_rdata;
  logic        udp_rec_sop;
  logic        udp_rec_eop;
  logic [15:0] udp_rec_data_length;
  logic [31:0] udp_rec_src_ip;
  logic [15:0] udp_rec_src_port;
  logic        udp_rec_err;
  logic        frame_drop;

  udp_receiver #(.LOCAL_MAC(LMAC), .LOCAL_IP(LIP), .LOCL_PORT(LPORT)) dut (
    .rgmii_clk           (rgmii_clk),
    .rstn                (rstn),
    .rx_valid            (rx_valid),
    .rx_data             (rx_data),
    .rx_error            (rx_error),
    .udp_rec_data_valid  (udp_rec_data_valid),
    .udp_rec_rdata       (udp_rec_rdata),
    .udp_rec_sop         (udp_rec_sop),
    .udp_rec_eop         (udp_rec_eop),
    .udp_rec_data_length (udp_rec_data_length),
    .udp_rec_src_ip      (udp_rec_src_ip),
    .udp_rec_src_port    (udp_rec_src_port),
    .udp_rec_err         (udp_rec_err),
    .frame_drop          (frame_drop)
  );

  always #4 rgmii_clk = ~rgmii_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [7:0] got_q[$];
  int sop_cnt, eop_cnt, err_cnt, drop_cnt, sop_idx, eop_idx;
  int ncyc = 0, fall_n = -100, errin_n = -100, err_n = -200;
  logic prev_rv = 1'b0;

  task automatic clear_mon();
    got_q.delete();
    sop_cnt = 0; eop_cnt = 0; err_cnt = 0; drop_cnt = 0;
    sop_idx = -1; eop_idx = -1; err_n = -200;
  endtask

  always @(negedge rgmii_clk) begin
    ncyc++;
    if (prev_rv && !rx_valid) fall_n = ncyc;
    prev_rv = rx_valid;
    if (rx_valid && rx_error) errin_n = ncyc;
    if (udp_rec_sop) begin sop_cnt++; sop_idx = got_q.size(); end
    if (udp_rec_eop) begin eop_cnt++; eop_idx = got_q.size(); end
    if (udp_rec_data_valid) got_q.push_back(udp_rec_rdata);
    if (udp_rec_err) begin err_cnt++; err_n = ncyc; end
    if (frame_drop) drop_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [7:0] b, input logic e);
    @(posedge rgmii_clk); #1;
    rx_valid = 1'b1; rx_data = b; rx_error = e;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge rgmii_clk); #1;
      rx_valid = 1'b0; rx_error = 1'b0; rx_data = 8'($urandom);
    end
  endtask

  typedef struct packed {
    logic [47:0] dmac;
    logic [15:0] etype;
    logic [7:0]  ver;
    logic [15:0] frag;
    logic [7:0]  proto;
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] sport;
    logic [15:0] dport;
  } hdr_t;

  logic [7:0] body[$];
  logic [7:0] frm[$];
  logic [7:0] pay[$];

  function automatic logic [31:0] crc_add(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic push_be(input logic [47:0] v, input int n);
    logic [47:0] t;
    for (int i = n - 1; i >= 0; i--) begin
      t = v >> (8 * i);
      body.push_back(t[7:0]);
    end
  endtask

  task automatic build(input hdr_t h, input bit flip);
    logic [31:0] crc;
    logic [15:0] ulen;
    ulen = 16'(pay.size() + 8);
    body.delete();
    push_be(h.dmac, 6);
    push_be(48'h02_00_5E_10_20_30, 6);
    push_be(48'(h.etype), 2);
    push_be(48'(h.ver), 1);
    push_be(48'd0, 1);
    push_be(48'(ulen + 16'd20), 2);
    push_be(48'($urandom), 2);
    push_be(48'(h.frag), 2);
    push_be(48'd64, 1);
    push_be(48'(h.proto), 1);
    push_be(48'd0, 2);
    push_be(48'(h.sip), 4);
    push_be(48'(h.dip), 4);
    push_be(48'(h.sport), 2);
    push_be(48'(h.dport), 2);
    push_be(48'(ulen), 2);
    push_be(48'd0, 2);
    foreach (pay[i]) body.push_back(pay[i]);
    while (body.size() < 60) body.push_back(8'h00);
    crc = 32'hFFFFFFFF;
    foreach (body[i]) crc = crc_add(crc, body[i]);
    crc = ~crc;
    if (flip) crc[5] = ~crc[5];
    for (int i = 0; i < 4; i++) begin
      body.push_back(crc[7:0]);
      crc = crc >> 8;
    end
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    foreach (body[i]) frm.push_back(body[i]);
  endtask

  function automatic hdr_t good_hdr(input logic [31:0] sip, input logic [15:0] sport);
    hdr_t h;
    h.dmac = LMAC; h.etype = 16'h0800; h.ver = 8'h45; h.frag = 16'h4000;
    h.proto = 8'd17; h.sip = sip; h.dip = LIP; h.sport = sport; h.dport = LPORT;
    return h;
  endfunction

  // ---------------- reference model ----------------
  logic [15:0] m_len = '0;
  logic [31:0] m_sip = '0;
  logic [15:0] m_sport = '0;

  // cut: number of frame bytes driven (-1 = all); err_at: byte index carrying rx_error (-1 = none)
  task automatic run_frame(input string nm, input hdr_t h, input bit flip, input int cut, input int err_at);
    bit accept, trunc, crc_err, exp_err, exp_drop, exp_eop;
    int n_exp, last;
    build(h, flip);
    accept = (h.dmac == LMAC || h.dmac == 48'hFFFF_FFFF_FFFF) && h.etype == 16'h0800 &&
             h.ver == 8'h45 && h.frag[13] == 1'b0 && h.frag[12:0] == 13'd0 &&
             h.proto == 8'd17 && h.dip == LIP && h.dport == LPORT;
    last     = (cut >= 0) ? cut : frm.size();
    trunc    = accept && (err_at < 0) && (last < 50 + pay.size());
    n_exp    = (!accept || err_at >= 0) ? 0 : (trunc ? last - 50 : pay.size());
    crc_err  = CRC_EN && flip && accept && !trunc && (err_at < 0);
    exp_err  = (err_at >= 0) || trunc || crc_err;
    exp_drop = !accept && (err_at < 0);
    exp_eop  = (n_exp > 0) && !trunc;
    clear_mon();
    for (int i = 0; i < last; i++) drive(frm[i], i == err_at);
    idle(6);
    if (n_exp > 0) begin
      m_len = 16'(pay.size()); m_sip = h.sip; m_sport = h.sport;
    end
    check_eq({nm, "/beats"}, 48'(got_q.size()), 48'(n_exp));
    for (int i = 0; i < n_exp; i++)
      if (i < got_q.size()) check_eq({nm, "/data"}, 48'(got_q[i]), 48'(pay[i]));
    check_eq({nm, "/sop_cnt"}, 48'(sop_cnt), (n_exp > 0) ? 48'd1 : 48'd0);
    if (n_exp > 0) check_eq({nm, "/sop_pos"}, 48'(sop_idx), 48'd0);
    check_eq({nm, "/eop_cnt"}, 48'(eop_cnt), exp_eop ? 48'd1 : 48'd0);
    if (exp_eop) check_eq({nm, "/eop_pos"}, 48'(eop_idx), 48'(n_exp - 1));
    check_eq({nm, "/err_cnt"}, 48'(err_cnt), exp_err ? 48'd1 : 48'd0);
    check_eq({nm, "/drop_cnt"}, 48'(drop_cnt), exp_drop ? 48'd1 : 48'd0);
    check_eq({nm, "/len"}, 48'(udp_rec_data_length), 48'(m_len));
    check_eq({nm, "/src_ip"}, 48'(udp_rec_src_ip), 48'(m_sip));
    check_eq({nm, "/src_port"}, 48'(udp_rec_src_port), 48'(m_sport));
    if (trunc || crc_err) check_eq({nm, "/err_lat"}, 48'(err_n - fall_n), 48'd1);
    if (err_at >= 0) check_eq({nm, "/err_lat"}, 48'(err_n - errin_n), 48'd1);
  endtask

  task automatic reset_mid_payload();
    logic [7:0] frm_a[$];
    hdr_t h;
    h = good_hdr(32'hC0A8_0101, 16'h4444);
    pay.delete();
    repeat (10) pay.push_back(8'($urandom));
    build(h, 1'b0);
    frm_a = frm;
    h = good_hdr(32'hC0A8_0202, 16'h5555);
    build(h, 1'b0);
    clear_mon();
    for (int i = 0; i < 55; i++) drive(frm_a[i], 1'b0);
    rstn = 1'b0;
    #1;
    check_eq("rst_mid/dv_data", {39'd0, udp_rec_data_valid, udp_rec_rdata}, 48'd0);
    check_eq("rst_mid/len_ip", {udp_rec_data_length, udp_rec_src_ip}, 48'd0);
    check_eq("rst_mid/port_flags", {28'd0, udp_rec_src_port, udp_rec_sop, udp_rec_eop, udp_rec_err, frame_drop}, 48'd0);
    drive(frm_a[55], 1'b0);
    drive(frm_a[56], 1'b0);
    rstn = 1'b1;
    clear_mon();
    // The tail of the interrupted frame runs straight into a complete good frame with no gap.
    for (int i = 57; i < frm_a.size(); i++) drive(frm_a[i], 1'b0);
    foreach (frm[i]) drive(frm[i], 1'b0);
    idle(6);
    m_len = '0; m_sip = '0; m_sport = '0;
    check_eq("rst_mid/beats", 48'(got_q.size()), 48'd0);
    check_eq("rst_mid/err_drop", 48'(err_cnt + drop_cnt), 48'd0);
    check_eq("rst_mid/meta", {udp_rec_data_length, udp_rec_src_ip}, 48'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    hdr_t h;
    #2 rstn = 1'b0;
    repeat (3) @(posedge rgmii_clk);
    #1;
    check_eq("reset/dv_data", {39'd0, udp_rec_data_valid, udp_rec_rdata}, 48'd0);
    check_eq("reset/len_ip", {udp_rec_data_length, udp_rec_src_ip}, 48'd0);
    check_eq("reset/port_flags", {28'd0, udp_rec_src_port, udp_rec_sop, udp_rec_eop, udp_rec_err, frame_drop}, 48'd0);
    rstn = 1'b1;
    idle(4);

    h = good_hdr(32'hC0A8_0169, 16'h1234);
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame("good", h, 1'b0, -1, -1);

    h.dport = 16'h8081;             run_frame("bad_port", h, 1'b0, -1, -1);
    h = good_hdr(32'hC0A8_0169, 16'h1234);
    h.etype = 16'h0806;             run_frame("arp", h, 1'b0, -1, -1);
    h = good_hdr(32'hC0A8_0169, 16'h1234);
    h.dip = 32'hC0A8_0170;          run_frame("bad_ip", h, 1'b0, -1, -1);

    h = good_hdr(32'h0A00_0001, 16'h0077);
    h.dmac = 48'hFFFF_FFFF_FFFF;
    pay = '{8'h5A};
    run_frame("bcast_1b", h, 1'b0, -1, -1);

    h = good_hdr(32'hC0A8_0169, 16'h1234);
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame("trunc", h, 1'b0, 52, -1);
    h = good_hdr(32'hC0A8_0133, 16'h2222);
    run_frame("after_trunc", h, 1'b0, -1, -1);

    run_frame("rx_error", h, 1'b0, -1, 25);
    run_frame("fcs_flip", h, 1'b1, -1, -1);

    pay.delete();
    h = good_hdr(32'hC0A8_0144, 16'h3333);
    run_frame("zero_len", h, 1'b0, -1, -1);

    reset_mid_payload();
    h = good_hdr(32'hC0A8_0155, 16'h6666);
    pay = '{8'h01, 8'h02, 8'h03};
    run_frame("after_reset", h, 1'b0, -1, -1);

    for (int t = 0; t < 40; t++) begin
      h = good_hdr($urandom, 16'($urandom));
      case ($urandom_range(0, 11))
        0: h.dmac = 48'hFFFF_FFFF_FFFF;
        1: h.dmac[$urandom_range(0, 47)] ^= 1'b1;
        2: h.etype = 16'h0806;
        3: h.ver = 8'h46;
        4: h.frag[13] = 1'b1;
        5: h.frag[12:0] = 13'($urandom_range(1, 8191));
        6: h.proto = 8'd6;
        7: h.dip[$urandom_range(0, 31)] ^= 1'b1;
        8: h.dport[$urandom_range(0, 15)] ^= 1'b1;
        9: h.frag = 16'h0000;
        default: ;
      endcase
      pay.delete();
      repeat ($urandom_range(0, 24)) pay.push_back(8'($urandom));
      run_frame("rand", h, ($urandom_range(0, 4) == 0), -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
